ir_prefetch_queue: RTL and testbench
====================================

Name: ir_prefetch_queue

Overview:
- Parametrised instruction register with a small prefetch queue between the memory bus and the control unit.
- Captures instruction words from the bus on a load strobe and buffers up to DEPTH of them in order.
- Presents the oldest word, plus decoded opcode and register fields, to the controller.
- Supports pop (advance), flush on branch/jump, and sticky overflow reporting.

Parameters:
- WIDTH, 16, instruction word width in bits.
- DEPTH, 4, queue entries; power of two, at least 2.
- OPC_W, 4, opcode field width, taken from the MSBs of the word.
- REG_W, 4, register field width; rd sits directly below opcode, rs directly below rd.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- bus_in  in  WIDTH  instruction word from the system bus.
- ir_en  in  1  load strobe; pushes bus_in at the rising clk edge.
- advance  in  1  controller has consumed the head word; pop it.
- flush  in  1  discard all queued words (branch taken).
- IR_OUT  out  WIDTH  head instruction word; 0 when empty.
- ir_valid  out  1  IR_OUT holds a valid word.
- opcode  out  OPC_W  IR_OUT[WIDTH-1 -: OPC_W].
- rd  out  REG_W  IR_OUT[WIDTH-1-OPC_W -: REG_W].
- rs  out  REG_W  IR_OUT[WIDTH-1-OPC_W-REG_W -: REG_W].
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH)+1  number of stored words.
- overflow  out  1  sticky: a push was dropped.

Behaviour:
- Reset (reset low, asynchronous): write pointer, read pointer and count go to 0; overflow=0; full=0; ir_valid=0; IR_OUT=0. Storage contents are don't-care. Outputs are never driven to Z.
- All state changes occur on rising clk edges while reset is high. reset deasserts synchronously to clk in the system.
- Push: ir_en=1 and (!full or advance) → mem[wr_ptr]<=bus_in; wr_ptr increments modulo DEPTH.
- Pop: advance=1 and count>0 → rd_ptr increments modulo DEPTH. advance while empty is ignored; no underflow.
- Simultaneous push and pop:
  - Count is unchanged.
  - When full, the push is accepted because a slot frees in the same edge.
  - When count==1, the new word becomes head on the next cycle.
- Drop: ir_en=1 while full with no advance → word discarded; overflow<=1; other state unchanged.
- Flush: has priority over push and pop in the same cycle.
  - Pointers and count go to 0; overflow clears; the same-cycle push is discarded.
- Outputs:
  - IR_OUT = mem[rd_ptr] when count>0, else 0.
  - ir_valid = (count!=0).
  - opcode, rd and rs are sliced from IR_OUT combinationally.
- Latency: a push into an empty queue at edge N makes IR_OUT and ir_valid valid after edge N (one cycle from strobe).
- Pointer wrap: pointers use $clog2(DEPTH) bits and wrap naturally; count distinguishes full from empty.
- Width rule: OPC_W + 2*REG_W <= WIDTH, enforced by an elaboration-time check. Low bits below rs are not decoded here.

Optional Feature:
- Macro: IR_BYPASS_EN.
- Defined:
  - When count==0 and ir_en=1, IR_OUT=bus_in and ir_valid=1 combinationally in the same cycle.
  - If advance=1 in that cycle, the word is consumed and not stored; count stays 0.
  - Otherwise the word is stored as usual.
  - flush still wins and suppresses the bypass on IR_OUT: IR_OUT=0, ir_valid=0.
- Undefined: no combinational path from bus_in or ir_en to IR_OUT; minimum latency is one cycle.

Test Plan:
- Reset low mid-operation with count=3 → IR_OUT=0, ir_valid=0, count=0, overflow=0 immediately, without waiting for a clk edge.
- Push 0x1234, 0xABCD, 0x0F0F on consecutive cycles → IR_OUT=0x1234, opcode=0x1, rd=0x2, rs=0x3, count=3. Advance twice → IR_OUT=0x0F0F.
- Fill to DEPTH=4, then ir_en with 0xDEAD and no advance → overflow=1, count=4, head unchanged. Next cycle ir_en plus advance → accepted, count=4.
- With count=2, flush and ir_en together (bus 0x5555) → count=0, ir_valid=0, overflow=0, 0x5555 discarded.
- Advance on an empty queue for 3 cycles → count stays 0; a subsequent push of 0x7777 gives IR_OUT=0x7777 after one edge.
- IR_BYPASS_EN defined, empty queue, ir_en=1 with bus 0x9ABC and advance=1 → IR_OUT=0x9ABC in the same cycle; count=0 after the edge.

Source files
------------

// File: rtl/ir_prefetch_queue.sv
// Instruction register fed by a DEPTH-entry in-order prefetch queue, with opcode/rd/rs decode of the head word.
// Define IR_BYPASS_EN to let a bus word reach IR_OUT in the same cycle when the queue is empty.
module ir_prefetch_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int OPC_W = 4,
  parameter int REG_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         bus_in,
  input  logic                     ir_en,
  input  logic                     advance,
  input  logic                     flush,
  output logic [WIDTH-1:0]         IR_OUT,
  output logic                     ir_valid,
  output logic [OPC_W-1:0]         opcode,
  output logic [REG_W-1:0]         rd,
  output logic [REG_W-1:0]         rs,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (OPC_W + 2 * REG_W > WIDTH) begin : g_width_chk
    $error("ir_prefetch_queue: OPC_W + 2*REG_W exceeds WIDTH");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("ir_prefetch_queue: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             empty, is_full, bypass_take, do_push, do_pop, do_drop;
  logic [WIDTH-1:0] head;
  logic             head_valid;

  always_comb begin
    empty   = (count_q == '0);
    is_full = (count_q == CW'(DEPTH));
`ifdef IR_BYPASS_EN
    bypass_take = empty && ir_en && advance;
`else
    bypass_take = 1'b0;
`endif
    // A full queue still accepts a push when the head is consumed on the same edge.
    do_push = ir_en && (!is_full || advance) && !bypass_take;
    do_pop  = advance && !empty;
    do_drop = ir_en && is_full && !advance;

    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (do_drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= bus_in;
  end

  always_comb begin
    head       = '0;
    head_valid = 1'b0;
    if (!empty) begin
      head       = mem_q[rd_q];
      head_valid = 1'b1;
    end
`ifdef IR_BYPASS_EN
    if (empty && ir_en && !flush) begin
      head       = bus_in;
      head_valid = 1'b1;
    end
`endif
  end

  assign IR_OUT   = head;
  assign ir_valid = head_valid;
  assign opcode   = head[WIDTH-1 -: OPC_W];
  assign rd       = head[WIDTH-1-OPC_W -: REG_W];
  assign rs       = head[WIDTH-1-OPC_W-REG_W -: REG_W];
  assign full     = is_full;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Self-checking bench for ir_prefetch_queue: directed scenarios then random traffic against a queue-based model.
// Honours IR_BYPASS_EN in the model when the design is built with it.
module tb_ir_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] busIn;
  logic        irEn, adv, fl;
  logic [15:0] irOut;
  logic        irValid, fullO, overflowO;
  logic [3:0]  opcodeO, rdO, rsO;
  logic [2:0]  countO;

  logic [15:0] modelQ[$];
  bit          modelOvf;
  int          total = 0;
  int          bad = 0;

  ir_prefetch_queue #(.WIDTH(16), .DEPTH(DEPTH), .OPC_W(4), .REG_W(4)) dut (
    .clk(clk), .reset(reset), .bus_in(busIn), .ir_en(irEn), .advance(adv), .flush(fl),
    .IR_OUT(irOut), .ir_valid(irValid), .opcode(opcodeO), .rd(rdO), .rs(rsO),
    .full(fullO), .count(countO), .overflow(overflowO)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs derived from the model queue contents and the current inputs.
  task automatic checkOutput(input string tag);
    logic [15:0] expIr;
    logic        expValid;
    expIr    = (modelQ.size() > 0) ? modelQ[0] : 16'h0;
    expValid = (modelQ.size() > 0);
`ifdef IR_BYPASS_EN
    if (modelQ.size() == 0 && irEn && !fl) begin
      expIr    = busIn;
      expValid = 1'b1;
    end
`endif
    checkValue({tag, ".ir"},     irOut,     expIr);
    checkValue({tag, ".valid"},  irValid,   expValid);
    checkValue({tag, ".opcode"}, opcodeO,   expIr[15:12]);
    checkValue({tag, ".rd"},     rdO,       expIr[11:8]);
    checkValue({tag, ".rs"},     rsO,       expIr[7:4]);
    checkValue({tag, ".full"},   fullO,     modelQ.size() == DEPTH);
    checkValue({tag, ".count"},  countO,    modelQ.size());
    checkValue({tag, ".ovf"},    overflowO, modelOvf);
  endtask

  function automatic void updateModel(input logic [15:0] b, input logic e, input logic a, input logic f);
    bit popOk, pushOk;
    if (f) begin
      modelQ.delete();
      modelOvf = 1'b0;
      return;
    end
`ifdef IR_BYPASS_EN
    if (modelQ.size() == 0 && e && a) return;
`endif
    popOk  = a && modelQ.size() > 0;
    pushOk = e && (modelQ.size() < DEPTH || a);
    if (e && !pushOk) modelOvf = 1'b1;
    if (popOk) void'(modelQ.pop_front());
    if (pushOk) modelQ.push_back(b);
  endfunction

  // One clock: drive on the falling edge, check just before the rising edge, then advance the model.
  task automatic applyStimulus(input string tag, input logic [15:0] b, input logic e, input logic a, input logic f);
    @(negedge clk);
    busIn = b; irEn = e; adv = a; fl = f;
    #1 checkOutput(tag);
    @(posedge clk);
    updateModel(b, e, a, f);
    #1;
  endtask

  initial begin
    reset = 1'b0; busIn = '0; irEn = 1'b0; adv = 1'b0; fl = 1'b0;
    modelOvf = 1'b0;
    #3;
    checkValue("rst.ir",    irOut,     16'h0);
    checkValue("rst.valid", irValid,   1'b0);
    checkValue("rst.count", countO,    3'd0);
    checkValue("rst.full",  fullO,     1'b0);
    checkValue("rst.ovf",   overflowO, 1'b0);
    @(negedge clk) reset = 1'b1;

    applyStimulus("push0", 16'h1234, 1, 0, 0);
    applyStimulus("push1", 16'hABCD, 1, 0, 0);
    applyStimulus("push2", 16'h0F0F, 1, 0, 0);
    checkValue("dec.ir",     irOut,   16'h1234);
    checkValue("dec.opcode", opcodeO, 4'h1);
    checkValue("dec.rd",     rdO,     4'h2);
    checkValue("dec.rs",     rsO,     4'h3);
    checkValue("dec.count",  countO,  3'd3);
    applyStimulus("adv0", 16'h0, 0, 1, 0);
    applyStimulus("adv1", 16'h0, 0, 1, 0);
    checkValue("adv.ir", irOut, 16'h0F0F);

    applyStimulus("fill0", 16'h1111, 1, 0, 0);
    applyStimulus("fill1", 16'h2222, 1, 0, 0);
    applyStimulus("fill2", 16'h3333, 1, 0, 0);
    checkValue("fill.full", fullO, 1'b1);
    applyStimulus("drop", 16'hDEAD, 1, 0, 0);
    checkValue("drop.ovf",   overflowO, 1'b1);
    checkValue("drop.count", countO,    3'd4);
    checkValue("drop.head",  irOut,     16'h0F0F);
    applyStimulus("pushpop", 16'h4444, 1, 1, 0);
    checkValue("pp.count", countO, 3'd4);
    checkValue("pp.head",  irOut,  16'h1111);
    applyStimulus("adv2", 16'h0, 0, 1, 0);
    checkValue("pre.count", countO, 3'd3);

    // Asynchronous reset asserted between clock edges.
    #2 reset = 1'b0;
    #1;
    checkValue("arst.ir",    irOut,     16'h0);
    checkValue("arst.valid", irValid,   1'b0);
    checkValue("arst.count", countO,    3'd0);
    checkValue("arst.ovf",   overflowO, 1'b0);
    modelQ.delete();
    modelOvf = 1'b0;
    @(negedge clk) reset = 1'b1;

    applyStimulus("f0", 16'hAAAA, 1, 0, 0);
    applyStimulus("f1", 16'hBBBB, 1, 0, 0);
    applyStimulus("f2", 16'hCCCC, 1, 0, 0);
    applyStimulus("f3", 16'hDDDD, 1, 0, 0);
    applyStimulus("fdrop", 16'hEEEE, 1, 0, 0);
    applyStimulus("fa0", 16'h0, 0, 1, 0);
    applyStimulus("fa1", 16'h0, 0, 1, 0);
    checkValue("fpre.count", countO, 3'd2);
    applyStimulus("flush", 16'h5555, 1, 0, 1);
    checkValue("flush.count", countO,    3'd0);
    checkValue("flush.valid", irValid,   1'b0);
    checkValue("flush.ovf",   overflowO, 1'b0);

    for (int i = 0; i < 3; i++) applyStimulus("eadv", 16'h0, 0, 1, 0);
    checkValue("eadv.count", countO, 3'd0);
    applyStimulus("p7777", 16'h7777, 1, 0, 0);
    checkValue("lat.ir",    irOut,   16'h7777);
    checkValue("lat.valid", irValid, 1'b1);
    applyStimulus("drain", 16'h0, 0, 1, 0);

`ifdef IR_BYPASS_EN
    @(negedge clk);
    busIn = 16'h9ABC; irEn = 1'b1; adv = 1'b1; fl = 1'b0;
    #1 checkValue("byp.ir", irOut, 16'h9ABC);
    checkValue("byp.valid", irValid, 1'b1);
    @(posedge clk);
    updateModel(16'h9ABC, 1, 1, 0);
    #1 checkValue("byp.count", countO, 3'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      applyStimulus("rnd", 16'($urandom), $urandom_range(0, 99) < 60,
                    $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 5);
    end
    applyStimulus("final", 16'h0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
